tc_sram_banked: RTL and testbench
=================================

// Module: tc_sram_banked
// PURPOSE
//   Parametrised, multi-bank single-port SRAM subsystem with valid/ready request and response channels.
//   Sits between the SoC bus bridge and the technology memory macros.
//   One request per cycle; selects a bank by address interleave; applies byte-masked writes.
//   Returns every request's response in order; a response FIFO absorbs back-pressure.
// PARAMETERS
//   DATA_W   32    data width in bits; multiple of 8
//   DEPTH    1024  words per bank; power of 2
//   BANKS    4     bank count; power of 2, >=1
//   INTLV    1     1: bank = addr[BW-1:0] (word interleave); 0: bank = addr[ADDR_W-1 -: BW]
//   OUT_REG  0     1: extra register stage after bank read data (read latency +1)
//   derived: BW=$clog2(BANKS) (0 when BANKS=1), ADDR_W=$clog2(DEPTH*BANKS), RSP_DEPTH=3+OUT_REG
// PORTS
//   clk_i        in   1            clock, rising edge
//   rst_i        in   1            asynchronous reset, active-high
//   req_valid_i  in   1            request valid
//   req_ready_o  out  1            request accepted when valid&ready
//   req_addr_i   in   ADDR_W       word address
//   req_wren_i   in   1            1 write, 0 read
//   req_mask_i   in   DATA_W/8     byte write enable, 1 = write byte (ignored on read)
//   req_data_i   in   DATA_W       write data
//   rsp_valid_o  out  1            response valid
//   rsp_ready_i  in   1            response consumed when valid&ready
//   rsp_data_o   out  DATA_W       read data; all-zero for write responses
//   rsp_wr_o     out  1            1 = response belongs to a write
// BEHAVIOUR
//   Reset: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_wr_o=0; credit counter=RSP_DEPTH; FIFO empty.
//   Reset does not clear memory array contents.
//   Credits: counter in 0..RSP_DEPTH.
//     Decrement on request accept; increment on response pop; both in the same cycle leave it unchanged.
//     req_ready_o = (credits!=0); registered/derived from state only.
//     No combinational path from rsp_ready_i or req_valid_i to req_ready_o.
//   Accept at edge k:
//     Exactly one bank has cs=1 at that edge; all other banks cs=0.
//     Bank wren=req_wren_i. Bank-local address = req_addr_i with bank bits removed.
//   Write: bytes with mask=1 updated at edge k; mask=0 bytes unchanged; mask all-zero writes nothing but still responds.
//   Read latency: bank data valid after edge k.
//     OUT_REG=0: data pushed to FIFO at edge k+1, so rsp_valid_o=1 in cycle after edge k+1 (2 cycles).
//     OUT_REG=1: data pushed to FIFO at edge k+2 (3 cycles).
//   In-flight tag pipeline (valid, wr, bank id) follows data; read mux uses the delayed bank id.
//   FIFO: RSP_DEPTH entries, in order, registered output, no bypass.
//     Push and pop in the same cycle are allowed, including when the FIFO is full.
//     Credits guarantee the FIFO never overflows. Push into a full FIFO is an assertion failure.
//   Throughput: with rsp_ready_i held 1, one request accepted every cycle indefinitely.
//   Back-pressure: with rsp_ready_i=0, exactly RSP_DEPTH requests are accepted, then req_ready_o=0.
//     Responses are held stable while rsp_valid_o&!rsp_ready_i.
//   Read after write, same address, consecutive cycles: the read returns the newly written data.
//     Single port, so the write completes at edge k and the read occurs at edge k+1.
//   Reset mid-operation: in-flight tags and FIFO entries are discarded; no response is produced for them.
//     A write coinciding with the reset-asserting edge is undefined.
// STRUCTURE
//   Shared package tc_sram_pkg: localparam functions clog2-safe bank width; rsp tag struct {wr, bank}.
//   Sub-module tc_sram_bank: generic 1-port RAM (DATA_W, DEPTH, byte mask, 1-cycle read, no reset).
//     Instantiated BANKS times via generate.
//     Tech-specific macros are bound inside tc_sram_bank only.
//   Top: bank decode, tag pipeline, optional OUT_REG stage, response FIFO, credit counter.
// TESTING
//   1 Reset, then write 0xDEADBEEF @0x004 mask 4'hF, read 0x004 -> write rsp (data 0, wr=1), then read rsp 0xDEADBEEF.
//     Read rsp_valid asserted 2 cycles after accept (3 with OUT_REG=1).
//   2 Write 0x11223344 @0x010, then write 0xAABBCCDD mask 4'b0101 @0x010, read -> 0x11BB33DD.
//   3 Stream 64 reads over addresses 0..63 with rsp_ready_i=1 -> req_ready_o never drops, responses in order.
//     Data matches the model; each bank is hit every 4th cycle (INTLV=1).
//   4 Hold rsp_ready_i=0, offer 8 reads -> exactly RSP_DEPTH accepted, req_ready_o=0.
//     Then rsp_ready_i=1 -> all responses drained in order with no loss or duplication.
//   5 Assert rst_i with 2 reads in flight and 1 in FIFO -> rsp_valid_o=0 immediately, credits=RSP_DEPTH.
//     No stale response appears after release; previously written data remains readable.
//   6 Random regression across BANKS∈{1,4}, INTLV∈{0,1}, OUT_REG∈{0,1} against a scoreboard.
//     Assert one-hot bank cs per cycle and that the FIFO never overflows.

Source files
------------

// File: rtl/tc_sram_pkg.sv
// Shared definitions for the banked SRAM subsystem: bank-width helper and response tag.
package tc_sram_pkg;

    localparam int MAX_BW = 8;

    function automatic int bank_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction

    typedef struct packed {
        logic              wr;
        logic [MAX_BW-1:0] bank;
    } rsp_tag_t;

endpackage

// File: rtl/tc_sram_bank.sv
// Generic single-port RAM with byte-masked writes and a one-cycle registered read; no reset.
module tc_sram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int MW    = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              cs_i,
    input  logic              wren_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [MW-1:0]     mask_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Technology macros replace this array; the read register models the macro output latch.
    always_ff @(posedge clk_i) begin
        if (cs_i) begin
            if (wren_i) begin
                for (int i = 0; i < MW; i++) begin
                    if (mask_i[i]) r_mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
                end
            end else begin
                rdata_o <= r_mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/tc_sram_banked.sv
// Multi-bank SRAM front end: bank decode, tag pipeline, optional output register,
// credit-protected in-order response FIFO.
module tc_sram_banked
    import tc_sram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int BANKS   = 4,
    parameter int INTLV   = 1,
    parameter int OUT_REG = 0,
    localparam int ADDR_W = $clog2(DEPTH * BANKS),
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wren_i,
    input  logic [MASK_W-1:0] req_mask_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_wr_o
);

    localparam int BW        = bank_width(BANKS);
    localparam int SW        = (BW == 0) ? 1 : BW;
    localparam int LW        = $clog2(DEPTH);
    localparam int RSP_DEPTH = 3 + OUT_REG;
    localparam int CW        = $clog2(RSP_DEPTH + 1);
    localparam int PW        = $clog2(RSP_DEPTH);

    logic [CW-1:0]     r_credit;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
    logic              r_fifo_wr   [RSP_DEPTH];

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_push_wr;
    logic [DATA_W-1:0] w_push_data;
    logic [SW-1:0]     w_bank_sel;
    logic [LW-1:0]     w_laddr;
    logic [BANKS-1:0]  w_cs;
    logic [DATA_W-1:0] w_rdata [BANKS];
    logic [DATA_W-1:0] w_bank_rd;
    logic [DATA_W-1:0] w_data_p0;

    logic              r_vld_p0;
    rsp_tag_t          r_tag_p0;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_ready_o = (r_credit != '0);
    assign w_accept    = req_valid_i && req_ready_o && !rst_i;
    assign rsp_valid_o = (r_count != '0);
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    // Bank decode: the bank bits are stripped to form the bank-local word address.
    if (BANKS == 1) begin : g_one_bank
        assign w_bank_sel = '0;
        assign w_laddr    = req_addr_i;
    end else if (INTLV != 0) begin : g_word_intlv
        assign w_bank_sel = req_addr_i[BW-1:0];
        assign w_laddr    = req_addr_i[ADDR_W-1:BW];
    end else begin : g_block_intlv
        assign w_bank_sel = req_addr_i[ADDR_W-1 -: BW];
        assign w_laddr    = req_addr_i[LW-1:0];
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign w_cs[b] = w_accept && (w_bank_sel == SW'(b));
        tc_sram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
            .clk_i   (clk_i),
            .cs_i    (w_cs[b]),
            .wren_i  (req_wren_i),
            .addr_i  (w_laddr),
            .mask_i  (req_mask_i),
            .data_i  (req_data_i),
            .rdata_o (w_rdata[b])
        );
    end

    // Stage p0: bank output valid, tag selects which bank drives the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_vld_p0 <= 1'b0;
        else       r_vld_p0 <= w_accept;
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_tag_p0.wr   <= req_wren_i;
            r_tag_p0.bank <= MAX_BW'(w_bank_sel);
        end
    end

    always_comb begin
        w_bank_rd = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (r_tag_p0.bank == MAX_BW'(b)) w_bank_rd = w_rdata[b];
        end
    end

    assign w_data_p0 = r_tag_p0.wr ? '0 : w_bank_rd;

    // Stage p1 (optional): retimes the bank read mux away from the FIFO write port.
    if (OUT_REG != 0) begin : g_oreg
        logic              r_vld_p1;
        logic              r_wr_p1;
        logic [DATA_W-1:0] r_data_p1;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) r_vld_p1 <= 1'b0;
            else       r_vld_p1 <= r_vld_p0;
        end

        always_ff @(posedge clk_i) begin
            if (r_vld_p0) begin
                r_wr_p1   <= r_tag_p0.wr;
                r_data_p1 <= w_data_p0;
            end
        end

        assign w_push      = r_vld_p1;
        assign w_push_wr   = r_wr_p1;
        assign w_push_data = r_data_p1;
    end else begin : g_no_oreg
        assign w_push      = r_vld_p0;
        assign w_push_wr   = r_tag_p0.wr;
        assign w_push_data = w_data_p0;
    end

    // Response FIFO: credits reserve a slot at accept, so a push always finds room.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= nxt_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= nxt_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_wr[r_wr_ptr]   <= w_push_wr;
        end
    end

    assign rsp_data_o = rsp_valid_o ? r_fifo_data[r_rd_ptr] : '0;
    assign rsp_wr_o   = rsp_valid_o && r_fifo_wr[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credit <= CW'(RSP_DEPTH);
        end else if (w_accept && !w_pop) begin
            r_credit <= r_credit - CW'(1);
        end else if (!w_accept && w_pop) begin
            r_credit <= r_credit + CW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));

    a_cs_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(w_cs));

endmodule

// File: tb/tb_tc_sram_banked.sv
// Directed and random checks of tc_sram_banked in the word-interleaved, 4-bank configuration.
module tb_tc_sram_banked;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int BANKS     = 4;
    localparam int INTLV     = 1;
    localparam int OUT_REG   = 0;
    localparam int ADDR_W    = $clog2(DEPTH * BANKS);
    localparam int RSP_DEPTH = 3 + OUT_REG;
    localparam int LAT       = 1 + OUT_REG;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_wren_i;
    logic [3:0]        req_mask_i;
    logic [DATA_W-1:0] req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_wr_o;

    always #5 clk_i = ~clk_i;

    tc_sram_banked #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BANKS(BANKS), .INTLV(INTLV), .OUT_REG(OUT_REG)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wren_i  (req_wren_i),
        .req_mask_i  (req_mask_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_wr_o    (rsp_wr_o)
    );

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    logic [31:0] model [64];
    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    int cs_err = 0;
    int ovf_err = 0;
    bit rand_rdy = 1'b0;

    // Response collector and per-cycle structural monitors, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) got_q.push_back({rsp_wr_o, rsp_data_o});
        if ($countones(dut.w_cs) != ((req_valid_i && req_ready_o && !rst_i) ? 1 : 0)) cs_err++;
        if (int'(dut.r_count) > RSP_DEPTH) ovf_err++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        if (rand_rdy) rsp_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic wr, input int addr, input logic [3:0] mask, input logic [31:0] data);
        int b;
        b = 0;
        req_valid_i = 1'b1;
        req_wren_i  = wr;
        req_addr_i  = ADDR_W'(addr);
        req_mask_i  = mask;
        req_data_i  = data;
        while (!req_ready_o && b < 200) begin
            step();
            b++;
        end
        if (req_ready_o) step();
        else to_cnt++;
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        req_wren_i  = 1'b0;
        req_mask_i  = '0;
        req_data_i  = '0;
    endtask

    task automatic wait_rsp(input int n);
        int b;
        b = 0;
        while (got_q.size() < n && b < 500) begin
            step();
            b++;
        end
        if (got_q.size() < n) to_cnt++;
    endtask

    task automatic model_write(input int addr, input logic [3:0] mask, input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) model[addr][8*i +: 8] = data[8*i +: 8];
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid_o); end
        checks++; if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rsp_data_o); end
        checks++; if (rsp_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", rsp_wr_o); end
        checks++; if (int'(dut.r_credit) !== RSP_DEPTH) begin errors++; $display("FAIL reset_credit got %0d want %0d", dut.r_credit, RSP_DEPTH); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        to_cnt = 0;
        rsp_ready_i = 1'b1;
        send(1'b1, 'h004, 4'hF, 32'hDEADBEEF);
        model_write('h004, 4'hF, 32'hDEADBEEF);
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early got valid %b want 0", rsp_valid_o); end
        send(1'b0, 'h004, 4'h0, 32'h0);
        idle();
        for (int i = 1; i < LAT; i++) step();
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL basic_wvalid got %b want 1", rsp_valid_o); end
        checks++; if (rsp_wr_o !== 1'b1) begin errors++; $display("FAIL basic_wflag got %b want 1", rsp_wr_o); end
        checks++; if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL basic_wdata got %h want 0", rsp_data_o); end
        step();
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL basic_rvalid got %b want 1", rsp_valid_o); end
        checks++; if (rsp_wr_o !== 1'b0) begin errors++; $display("FAIL basic_rflag got %b want 0", rsp_wr_o); end
        checks++; if (rsp_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got %h want deadbeef", rsp_data_o); end
        step();
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain got valid %b want 0", rsp_valid_o); end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    task automatic test_mask();
        to_cnt = 0;
        got_q.delete();
        rsp_ready_i = 1'b1;
        send(1'b1, 'h010, 4'hF, 32'h11223344);
        send(1'b1, 'h010, 4'b0101, 32'hAABBCCDD);
        send(1'b0, 'h010, 4'h0, 32'h0);
        idle();
        wait_rsp(3);
        model_write('h010, 4'hF, 32'h11BB33DD);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL mask_count got %0d want 3", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== {1'b1, 32'h0}) begin errors++; $display("FAIL mask_w0 got %h want %h", got_q[0], {1'b1, 32'h0}); end
            checks++; if (got_q[1] !== {1'b1, 32'h0}) begin errors++; $display("FAIL mask_w1 got %h want %h", got_q[1], {1'b1, 32'h0}); end
            checks++; if (got_q[2] !== {1'b0, 32'h11BB33DD}) begin errors++; $display("FAIL mask_rd got %h want %h", got_q[2], {1'b0, 32'h11BB33DD}); end
        end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL mask_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    task automatic test_stream();
        int drops;
        int cs_bad;
        logic [3:0] exp_cs;
        to_cnt = 0;
        drops = 0;
        cs_bad = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(1'b1, i, 4'hF, 32'h9E3779B1 * (i + 1));
            model_write(i, 4'hF, 32'h9E3779B1 * (i + 1));
        end
        idle();
        wait_rsp(64);
        got_q.delete();
        req_valid_i = 1'b1;
        req_wren_i  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            req_addr_i = ADDR_W'(i);
            exp_cs = 4'b0001 << (i % BANKS);
            #1;
            if (req_ready_o !== 1'b1) drops++;
            if (dut.w_cs !== exp_cs) cs_bad++;
            step();
        end
        idle();
        wait_rsp(64);
        checks++; if (drops !== 0) begin errors++; $display("FAIL stream_ready_drops got %0d want 0", drops); end
        checks++; if (cs_bad !== 0) begin errors++; $display("FAIL stream_bank_cs got %0d bad cycles want 0", cs_bad); end
        checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL stream_count got %0d want 64", got_q.size()); end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {1'b0, model[i]}) begin
                errors++;
                $display("FAIL stream_data[%0d] got %h want %h", i, got_q[i], {1'b0, model[i]});
            end
        end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL stream_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    task automatic test_backpressure();
        int acc;
        logic rdy_now;
        to_cnt = 0;
        acc = 0;
        got_q.delete();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_wren_i  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_addr_i = ADDR_W'(acc);
            rdy_now = req_ready_o;
            step();
            if (rdy_now) acc++;
        end
        checks++; if (acc !== RSP_DEPTH) begin errors++; $display("FAIL bp_accepted got %0d want %0d", acc, RSP_DEPTH); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", rsp_valid_o); end
        checks++; if (rsp_data_o !== model[0]) begin errors++; $display("FAIL bp_head got %h want %h", rsp_data_o, model[0]); end
        step();
        step();
        step();
        checks++; if (rsp_data_o !== model[0] || rsp_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_stable got %b/%h want 1/%h", rsp_valid_o, rsp_data_o, model[0]);
        end
        idle();
        rsp_ready_i = 1'b1;
        wait_rsp(RSP_DEPTH);
        for (int i = 0; i < 4; i++) step();
        checks++; if (got_q.size() !== RSP_DEPTH) begin errors++; $display("FAIL bp_drain_count got %0d want %0d", got_q.size(), RSP_DEPTH); end
        for (int i = 0; i < RSP_DEPTH && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {1'b0, model[i]}) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h want %h", i, got_q[i], {1'b0, model[i]});
            end
        end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_credit_back got %b want 1", req_ready_o); end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        to_cnt = 0;
        got_q.delete();
        rsp_ready_i = 1'b0;
        send(1'b0, 1, 4'h0, 32'h0);
        send(1'b0, 2, 4'h0, 32'h0);
        send(1'b0, 3, 4'h0, 32'h0);
        idle();
        rst_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", rsp_valid_o); end
        checks++; if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL rmid_data got %h want 0", rsp_data_o); end
        checks++; if (int'(dut.r_credit) !== RSP_DEPTH) begin errors++; $display("FAIL rmid_credit got %0d want %0d", dut.r_credit, RSP_DEPTH); end
        step();
        step();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rmid_stale got %0d responses want 0", got_q.size()); end
        send(1'b0, 5, 4'h0, 32'h0);
        idle();
        wait_rsp(1);
        checks++; if (got_q.size() < 1 || got_q[0] !== {1'b0, model[5]}) begin
            errors++; $display("FAIL rmid_retained got %h want %h", (got_q.size() > 0) ? got_q[0] : 33'h0, {1'b0, model[5]});
        end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL rmid_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    task automatic test_random();
        logic        wr;
        int          addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          bad;
        to_cnt = 0;
        bad = 0;
        cs_err = 0;
        ovf_err = 0;
        got_q.delete();
        exp_q.delete();
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 63);
            mask = 4'($urandom);
            data = $urandom;
            if (wr) begin
                model_write(addr, mask, data);
                exp_q.push_back({1'b1, 32'h0});
            end else begin
                exp_q.push_back({1'b0, model[addr]});
            end
            send(wr, addr, mask, data);
        end
        idle();
        rand_rdy = 1'b0;
        rsp_ready_i = 1'b1;
        wait_rsp(150);
        for (int i = 0; i < 4; i++) step();
        checks++; if (got_q.size() !== 150) begin errors++; $display("FAIL rand_count got %0d want 150", got_q.size()); end
        for (int i = 0; i < 150 && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_rsp[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_data got %0d mismatching responses want 0", bad); end
        checks++; if (cs_err !== 0) begin errors++; $display("FAIL rand_cs_onehot got %0d bad cycles want 0", cs_err); end
        checks++; if (ovf_err !== 0) begin errors++; $display("FAIL rand_overflow got %0d bad cycles want 0", ovf_err); end
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", to_cnt); end
        got_q.delete();
    endtask

    initial begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        req_addr_i  = '0;
        idle();
        test_reset();
        test_basic();
        test_mask();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
